reg_bank_ctrl: RTL and testbench

Request/response front end for the team's register bank: accepts single read or write transactions over a valid/ready handshake and decodes the address into a one-hot select vector that drives the `select` input of each bank register. It broadcasts write data to the bank and returns read data from the concatenated bank outputs. It sits directly upstream of the per-register storage elements and is their only driver.

---
 rtl/reg_bank_if.sv | 29 ++
 rtl/reg_bank_ctrl.sv | 120 ++++++++++++
 tb/tb_reg_bank_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// reg_bank_if: request/response handshake plus bank select/data buses for reg_bank_ctrl.
interface reg_bank_if #(
    parameter int unsigned A = 8,
    parameter int unsigned D = 8,
    parameter int unsigned R = 256
) ();
    logic           req_valid;
    logic           req_ready;
    logic           req_wr;
    logic [A-1:0]   req_addr;
    logic [D-1:0]   req_wdata;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [D-1:0]   rsp_rdata;
    logic           rsp_err;
    logic [R-1:0]   sel;
    logic [D-1:0]   wdata;
    logic [R*D-1:0] qbus;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, qbus,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, sel, wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready, qbus,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, sel, wdata
    );
endinterface

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: valid/ready front end decoding single reads/writes into one-hot bank selects.
// Optional macro ADDR_RANGE_CHK_EN: out-of-range requests skip the bank and answer with rsp_err.
module reg_bank_ctrl #(
    parameter int unsigned A = 8,
    parameter int unsigned D = 8,
    parameter int unsigned R = 256
) (
    input  logic      clk,
    input  logic      reset,
    reg_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    state_t       state_q;
    state_t       state_d;
    logic [A-1:0] addr_l;
    logic [D-1:0] wdata_q;
    logic [D-1:0] rdata_q;
    logic         accept_c;
    logic [R-1:0] dec_c;
    logic [D-1:0] rd_word_c;

    assign accept_c = (state_q == IDLE) && bus.req_valid;

    // Latched-address decode; an address at or beyond R matches nothing, so sel and read data are zero.
    always_comb begin
        dec_c     = '0;
        rd_word_c = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (32'(addr_l) == i) begin
                dec_c[i]  = 1'b1;
                rd_word_c = bus.qbus[i*D +: D];
            end
        end
    end

`ifdef ADDR_RANGE_CHK_EN
    logic err_q;
    logic req_oor_c;
    assign req_oor_c = 32'(bus.req_addr) >= R;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake/select outputs; sel and req_ready are gated by reset in the same cycle.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.sel       = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = !reset;
                if (bus.req_valid) begin
                    state_d = bus.req_wr ? WR : RD;
`ifdef ADDR_RANGE_CHK_EN
                    if (req_oor_c) begin
                        state_d = RSP;
                    end
`endif
                end
            end
            WR: begin
                bus.sel = reset ? '0 : dec_c;
                state_d = RSP;
            end
            RD: begin
                state_d = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_l  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept_c) begin
                addr_l  <= bus.req_addr;
                rdata_q <= '0;
                if (bus.req_wr) begin
                    wdata_q <= bus.req_wdata;
                end
            end
            if (state_q == RD) begin
                rdata_q <= rd_word_c;
            end
        end
    end

`ifdef ADDR_RANGE_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept_c) begin
            err_q <= req_oor_c;
        end
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.wdata     = wdata_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: directed plus random transactions against a bank model and expected-value array.
module tb_reg_bank_ctrl;
    localparam int unsigned A = 8;
    localparam int unsigned D = 8;
    localparam int unsigned R = 200;
`ifdef ADDR_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bank_clr = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [D-1:0] bank  [R];
    logic [D-1:0] model [R];
    logic [D-1:0] last_wdata;

    reg_bank_if #(.A(A), .D(D), .R(R)) bus ();
    reg_bank_ctrl #(.A(A), .D(D), .R(R)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Bank registers: seeded once, then loaded from wdata wherever sel is high.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(R); i++) begin
            if (bank_clr) bank[i] <= D'(i * 7 + 3);
            else if (bus.sel[i]) bank[i] <= bus.wdata;
        end
    end

    always_comb begin
        bus.qbus = '0;
        for (int i = 0; i < int'(R); i++) bus.qbus[i*D +: D] = bank[i];
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset_vals();
        chk("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        chk("rst_rsp_rdata", 256'(bus.rsp_rdata), 256'(0));
        chk("rst_rsp_err",   256'(bus.rsp_err),   256'(0));
        chk("rst_sel",       256'(bus.sel),       256'(0));
        chk("rst_wdata",     256'(bus.wdata),     256'(0));
        chk("rst_req_ready", 256'(bus.req_ready), 256'(1));
    endtask

    // One transaction; hold = cycles rsp_ready stays low while a stray request is offered.
    task automatic txn(input bit wr, input logic [A-1:0] addr, input logic [D-1:0] data, input int hold);
        int           cnt;
        int           lat;
        int           sel_cycles;
        logic [R-1:0] sel_acc;
        logic [R-1:0] exp_mask;
        logic [D-1:0] exp_rd;
        logic [D-1:0] held_rd;
        bit           oor;
        bit           exp_err;
        oor      = 32'(addr) >= R;
        exp_err  = CHK && oor;
        exp_mask = '0;
        if (wr && !oor) exp_mask[addr] = 1'b1;
        exp_rd   = (wr || oor) ? '0 : model[addr];
        if (wr && !oor) model[addr] = data;
        if (wr) last_wdata = data;

        cnt = 0;
        while (!bus.req_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("req_ready_idle", 256'(bus.req_ready), 256'(1));
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.rsp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        lat = 0; sel_cycles = 0; sel_acc = '0;
        while (!bus.rsp_valid && lat < 5) begin
            if (bus.sel != '0) begin
                sel_cycles++;
                sel_acc |= bus.sel;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_latency", 256'(lat), 256'(exp_err ? 0 : 1));
        chk("sel_cycles",  256'(sel_cycles), 256'((wr && !oor) ? 1 : 0));
        chk("sel_onehot",  256'(sel_acc), 256'(exp_mask));
        chk("rsp_rdata",   256'(bus.rsp_rdata), 256'(exp_rd));
        chk("rsp_err",     256'(bus.rsp_err), 256'(exp_err));
        chk("busy_ready",  256'(bus.req_ready), 256'(0));
        chk("rsp_sel",     256'(bus.sel), 256'(0));
        chk("wdata_bus",   256'(bus.wdata), 256'(last_wdata));
        if (!oor) chk("bank_word", 256'(bank[addr]), 256'(model[addr]));

        held_rd = exp_rd;
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'($urandom_range(0, 1));
            bus.req_addr  = A'($urandom_range(0, 255));
            bus.req_wdata = D'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 256'(bus.rsp_valid), 256'(1));
            chk("hold_rdata", 256'(bus.rsp_rdata), 256'(held_rd));
            chk("hold_ready", 256'(bus.req_ready), 256'(0));
            chk("hold_sel",   256'(bus.sel), 256'(0));
            chk("hold_wdata", 256'(bus.wdata), 256'(last_wdata));
        end
        if (hold > 0) begin
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("rsp_drop",  256'(bus.rsp_valid), 256'(0));
        chk("idle_back", 256'(bus.req_ready), 256'(1));
    endtask

    initial begin
        logic [R-1:0] m2;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        last_wdata    = '0;
        for (int i = 0; i < int'(R); i++) model[i] = D'(i * 7 + 3);

        repeat (2) @(posedge clk);
        #1;
        chk("ready_during_reset", 256'(bus.req_ready), 256'(0));
        reset = 1'b0;
        bank_clr = 1'b0;
        #1;
        chk_idle_reset_vals();

        txn(1'b1, 8'h05, 8'hA5, 0);
        txn(1'b1, 8'h10, 8'h3C, 0);
        txn(1'b0, 8'h10, 8'h00, 0);
        chk("readback_0x10", 256'(bus.rsp_rdata), 256'(8'h3C));
        txn(1'b0, 8'h07, 8'h00, 5);

        // Reset lands in the WR cycle of a write to 0x02: bank keeps its previous value.
        txn(1'b1, 8'h02, 8'h11, 0);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 8'h02;
        bus.req_wdata = 8'h77;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        m2 = '0;
        m2[2] = 1'b1;
        chk("sel_before_reset", 256'(bus.sel), 256'(m2));
        reset = 1'b1;
        #1;
        chk("sel_in_reset",   256'(bus.sel), 256'(0));
        chk("ready_in_reset", 256'(bus.req_ready), 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        last_wdata = '0;
        #1;
        chk_idle_reset_vals();
        chk("bank_kept_0x02", 256'(bank[2]), 256'(8'h11));
        txn(1'b0, 8'h02, 8'h00, 0);

        txn(1'b1, 8'hF0, 8'h5A, 0);
        txn(1'b0, 8'hF0, 8'h00, 0);
        txn(1'b0, 8'hC7, 8'h00, 1);

        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom_range(0, 1)), A'($urandom_range(0, 255)), D'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
